// File: rtl/sdm_tx.sv
// sdm_tx: sigma-delta modulator / transmitter.
// Converts parallel signed PCM samples into a 1-bit direct stream (DSDOUT)
// plus its sigma-delta clock (SDCLKOUT); DSDOUT is meant to be sampled on the
// SDCLKOUT rising edge. First- or second-order loop with saturating integrators.
// Optional build macro SDM_DITHER_EN adds a 2-bit LFSR dither to the last
// integrator input; when undefined the loop is the plain reference loop.
module sdm_tx #(
  parameter int DW   = 16,
  parameter int ACCW = 24
) (
  input  logic          SYSCLK,
  input  logic          SYSRST,
  input  logic          reg_moden,
  input  logic          reg_modorder,
  input  logic [3:0]    reg_moddiv,
  input  logic [7:0]    reg_modosr,
  input  logic [DW-1:0] sample_data,
  input  logic          sample_valid,
  output logic          sample_ready,
  output logic          DSDOUT,
  output logic          SDCLKOUT,
  output logic          bit_strobe,
  output logic          mod_underflow
);

  // Extended width for integrator sums before saturation.
  localparam int EW = ACCW + 2;
  localparam logic signed [EW-1:0] FS_E  = {{(EW-DW){1'b0}}, 1'b1, {(DW-1){1'b0}}};
  localparam logic signed [EW-1:0] MAX_E = {{(EW-ACCW+1){1'b0}}, {(ACCW-1){1'b1}}};
  localparam logic signed [EW-1:0] MIN_E = {{(EW-ACCW+1){1'b1}}, {(ACCW-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRIME,
    S_RUN
  } state_t;

  state_t state_q, state_d;

  logic [3:0]             cnt_q, div_q;
  logic [7:0]             bitcnt_q;
  logic                   sdclk_q, dsd_q, strobe_q, uflow_q;
  logic [DW-1:0]          hold_q, cur_q;
  logic                   hold_full_q;
  logic signed [ACCW-1:0] i1_q, i2_q;
  logic                   order_q;

  logic                   run, prime, clr, load, term, tick, wrap;
  logic signed [EW-1:0]   x_e, fb_e, dith_e, d1_e, d2_e, s1, s2;
  logic signed [ACCW-1:0] i1_n, i2_n;
  logic                   dsd_n;

  function automatic logic signed [ACCW-1:0] sat(input logic signed [EW-1:0] v);
    if (v > MAX_E)      sat = MAX_E[ACCW-1:0];
    else if (v < MIN_E) sat = MIN_E[ACCW-1:0];
    else                sat = v[ACCW-1:0];
  endfunction

  // State register.
  always_ff @(posedge SYSCLK or posedge SYSRST) begin
    if (SYSRST) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; disabling the modulator wins from any state.
  always_comb begin
    state_d = state_q;
    if (!reg_moden) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_PRIME;
        S_PRIME: if (load) state_d = S_RUN;
        S_RUN:   state_d = S_RUN;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output / control decode from state and datapath registers.
  always_comb begin
    run           = (state_q == S_RUN);
    prime         = (state_q == S_PRIME);
    clr           = !reg_moden || (state_q == S_IDLE);
    sample_ready  = !hold_full_q;
    load          = sample_valid && sample_ready;
    term          = run && (cnt_q == div_q);
    tick          = term && sdclk_q;
    wrap          = tick && (bitcnt_q >= reg_modosr);
    DSDOUT        = dsd_q;
    SDCLKOUT      = sdclk_q;
    bit_strobe    = strobe_q;
    mod_underflow = uflow_q;
  end

`ifdef SDM_DITHER_EN
  logic [15:0] lfsr_q;

  // Galois LFSR x^16+x^14+x^13+x^11+1, one step per emitted bit.
  always_ff @(posedge SYSCLK or posedge SYSRST) begin
    if (SYSRST)    lfsr_q <= 16'hACE1;
    else if (clr)  lfsr_q <= 16'hACE1;
    else if (tick) lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  end

  // Signed 2-bit dither taken from the LFSR low bits.
  always_comb dith_e = {{(EW-2){lfsr_q[1]}}, lfsr_q[1:0]};
`else
  // No dither in the reference loop.
  always_comb dith_e = '0;
`endif

  // Loop arithmetic for the next bit; dither goes into the last integrator only.
  always_comb begin
    x_e   = {{(EW-DW){cur_q[DW-1]}}, cur_q};
    fb_e  = dsd_q ? FS_E : -FS_E;
    d1_e  = order_q ? '0 : dith_e;
    d2_e  = order_q ? dith_e : '0;
    s1    = {{(EW-ACCW){i1_q[ACCW-1]}}, i1_q} + x_e - fb_e + d1_e;
    i1_n  = sat(s1);
    s2    = {{(EW-ACCW){i2_q[ACCW-1]}}, i2_q} + {{(EW-ACCW){i1_n[ACCW-1]}}, i1_n} - fb_e + d2_e;
    i2_n  = sat(s2);
    dsd_n = order_q ? ~i2_n[ACCW-1] : ~i1_n[ACCW-1];
  end

  // Divider, bit loop, sample buffering; IDLE holds everything cleared and
  // silently drops any sample offered while disabled.
  always_ff @(posedge SYSCLK or posedge SYSRST) begin
    if (SYSRST) begin
      cnt_q       <= '0;
      div_q       <= '0;
      bitcnt_q    <= '0;
      sdclk_q     <= 1'b0;
      dsd_q       <= 1'b0;
      strobe_q    <= 1'b0;
      uflow_q     <= 1'b0;
      hold_q      <= '0;
      cur_q       <= '0;
      hold_full_q <= 1'b0;
      i1_q        <= '0;
      i2_q        <= '0;
      order_q     <= 1'b0;
    end else if (clr) begin
      cnt_q       <= '0;
      div_q       <= reg_moddiv;
      bitcnt_q    <= '0;
      sdclk_q     <= 1'b0;
      dsd_q       <= 1'b0;
      strobe_q    <= 1'b0;
      uflow_q     <= 1'b0;
      hold_q      <= '0;
      cur_q       <= '0;
      hold_full_q <= 1'b0;
      i1_q        <= '0;
      i2_q        <= '0;
      order_q     <= reg_modorder;
    end else begin
      strobe_q <= tick;
      uflow_q  <= wrap && !hold_full_q;

      // Divider: the divisor is re-latched only at terminal count.
      if (term) begin
        cnt_q   <= '0;
        div_q   <= reg_moddiv;
        sdclk_q <= ~sdclk_q;
      end else if (run) begin
        cnt_q <= cnt_q + 4'd1;
      end else begin
        div_q <= reg_moddiv;
      end

      // Bit emission on the SDCLKOUT falling toggle; an order change only
      // takes effect at a sample boundary, restarting from cleared integrators.
      if (tick) begin
        dsd_q    <= dsd_n;
        bitcnt_q <= wrap ? 8'd0 : bitcnt_q + 8'd1;
        if (wrap && (order_q != reg_modorder)) begin
          i1_q    <= '0;
          i2_q    <= '0;
          order_q <= reg_modorder;
        end else begin
          i1_q <= i1_n;
          if (order_q) i2_q <= i2_n;
        end
      end

      // First sample bypasses holding; afterwards holding feeds current at
      // each boundary, and an empty holding register leaves current reused.
      if (prime) begin
        order_q <= reg_modorder;
        if (load) cur_q <= sample_data;
      end else begin
        if (wrap && hold_full_q) cur_q <= hold_q;
        if (load) hold_q <= sample_data;
        hold_full_q <= load || (hold_full_q && !wrap);
      end
    end
  end

endmodule

// File: tb/tb_sdm_tx.sv
// Directed self-checking bench for sdm_tx.
module tb_sdm_tx;

  logic        SYSCLK = 1'b0;
  logic        SYSRST;
  logic        reg_moden;
  logic        reg_modorder;
  logic [3:0]  reg_moddiv;
  logic [7:0]  reg_modosr;
  logic [15:0] sample_data;
  logic        sample_valid;
  logic        sample_ready;
  logic        DSDOUT;
  logic        SDCLKOUT;
  logic        bit_strobe;
  logic        mod_underflow;

  int n_cmp = 0;
  int n_err = 0;

  sdm_tx #(.DW(16), .ACCW(24)) dut (
    .SYSCLK        (SYSCLK),
    .SYSRST        (SYSRST),
    .reg_moden     (reg_moden),
    .reg_modorder  (reg_modorder),
    .reg_moddiv    (reg_moddiv),
    .reg_modosr    (reg_modosr),
    .sample_data   (sample_data),
    .sample_valid  (sample_valid),
    .sample_ready  (sample_ready),
    .DSDOUT        (DSDOUT),
    .SDCLKOUT      (SDCLKOUT),
    .bit_strobe    (bit_strobe),
    .mod_underflow (mod_underflow)
  );

  always #5 SYSCLK = ~SYSCLK;

  // Offer one sample and hold it until accepted (bounded).
  task automatic send_sample(input logic [15:0] d);
    int n;
    @(negedge SYSCLK);
    sample_data  = d;
    sample_valid = 1'b1;
    n = 0;
    while (!sample_ready && n < 200) begin
      @(negedge SYSCLK);
      n++;
    end
    if (n >= 200) begin
      n_cmp++;
      n_err++;
      $display("FAIL handshake: ready never seen for sample %h", d);
    end
    @(negedge SYSCLK);
    sample_valid = 1'b0;
  endtask

  // Advance to the next negedge where bit_strobe is high; returns cycles waited.
  task automatic wait_strobe(output int cyc);
    cyc = 0;
    do begin
      @(negedge SYSCLK);
      cyc++;
    end while (!bit_strobe && cyc < 100);
    if (!bit_strobe) begin
      n_cmp++;
      n_err++;
      $display("FAIL strobe_timeout: no bit_strobe within %0d cycles", cyc);
    end
  endtask

  task automatic test_reset();
    SYSRST = 1'b1; reg_moden = 1'b0; reg_modorder = 1'b0;
    reg_moddiv = 4'd0; reg_modosr = 8'd0; sample_data = '0; sample_valid = 1'b0;
    repeat (3) @(negedge SYSCLK);
    n_cmp++; if (DSDOUT !== 1'b0)        begin n_err++; $display("FAIL rst_dsd: got %b exp 0", DSDOUT); end
    n_cmp++; if (SDCLKOUT !== 1'b0)      begin n_err++; $display("FAIL rst_sdclk: got %b exp 0", SDCLKOUT); end
    n_cmp++; if (sample_ready !== 1'b1)  begin n_err++; $display("FAIL rst_ready: got %b exp 1", sample_ready); end
    n_cmp++; if (bit_strobe !== 1'b0)    begin n_err++; $display("FAIL rst_strobe: got %b exp 0", bit_strobe); end
    n_cmp++; if (mod_underflow !== 1'b0) begin n_err++; $display("FAIL rst_uflow: got %b exp 0", mod_underflow); end
    SYSRST = 1'b0;
    repeat (3) @(negedge SYSCLK);
    n_cmp++; if (DSDOUT !== 1'b0)        begin n_err++; $display("FAIL idle_dsd: got %b exp 0", DSDOUT); end
    n_cmp++; if (SDCLKOUT !== 1'b0)      begin n_err++; $display("FAIL idle_sdclk: got %b exp 0", SDCLKOUT); end
    n_cmp++; if (sample_ready !== 1'b1)  begin n_err++; $display("FAIL idle_ready: got %b exp 1", sample_ready); end
  endtask

  // moddiv=1, order 0, x=0: bit every 4 SYSCLK, stream 1,1 then alternating.
  task automatic test_alternating();
    logic exp_bits [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    int cyc;
    reg_moddiv = 4'd1; reg_modosr = 8'd31; reg_modorder = 1'b0;
    reg_moden = 1'b1;
    @(negedge SYSCLK);
    send_sample(16'h0000);
    for (int k = 0; k < 8; k++) begin
      wait_strobe(cyc);
      n_cmp++; if (cyc !== 4)            begin n_err++; $display("FAIL alt_period[%0d]: got %0d exp 4", k, cyc); end
      n_cmp++; if (DSDOUT !== exp_bits[k]) begin n_err++; $display("FAIL alt_bit[%0d]: got %b exp %b", k, DSDOUT, exp_bits[k]); end
      n_cmp++; if (SDCLKOUT !== 1'b0)    begin n_err++; $display("FAIL alt_sdclk_fall[%0d]: got %b exp 0", k, SDCLKOUT); end
    end
    repeat (2) @(negedge SYSCLK);
    n_cmp++; if (SDCLKOUT !== 1'b1) begin n_err++; $display("FAIL alt_sdclk_rise: got %b exp 1", SDCLKOUT); end
  endtask

  // Dropping reg_moden forces outputs low on the next SYSCLK.
  task automatic test_disable();
    n_cmp++; if (DSDOUT !== 1'b1) begin n_err++; $display("FAIL dis_pre_dsd: got %b exp 1", DSDOUT); end
    reg_moden = 1'b0;
    @(negedge SYSCLK);
    n_cmp++; if (DSDOUT !== 1'b0)       begin n_err++; $display("FAIL dis_dsd: got %b exp 0", DSDOUT); end
    n_cmp++; if (SDCLKOUT !== 1'b0)     begin n_err++; $display("FAIL dis_sdclk: got %b exp 0", SDCLKOUT); end
    n_cmp++; if (sample_ready !== 1'b1) begin n_err++; $display("FAIL dis_ready: got %b exp 1", sample_ready); end
    n_cmp++; if (bit_strobe !== 1'b0)   begin n_err++; $display("FAIL dis_strobe: got %b exp 0", bit_strobe); end
  endtask

  // Order 2, x=FS/2: hand-traced start, then period-8 pattern with 6 ones;
  // 256 bits give 9 + 30*6 + 4 = 193 ones.
  task automatic test_order2_half();
    logic exp_bits [12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1,
                            1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    int cyc;
    int ones;
    reg_moddiv = 4'd0; reg_modosr = 8'd255; reg_modorder = 1'b1;
    @(negedge SYSCLK);
    reg_moden = 1'b1;
    @(negedge SYSCLK);
    send_sample(16'h4000);
    ones = 0;
    for (int k = 0; k < 256; k++) begin
      wait_strobe(cyc);
      if (k < 12) begin
        n_cmp++; if (DSDOUT !== exp_bits[k]) begin n_err++; $display("FAIL o2_bit[%0d]: got %b exp %b", k, DSDOUT, exp_bits[k]); end
      end
      if (DSDOUT === 1'b1) ones++;
    end
    n_cmp++; if (ones !== 193) begin n_err++; $display("FAIL o2_density: got %0d ones exp 193", ones); end
    reg_moden = 1'b0;
    @(negedge SYSCLK);
  endtask

  // x=+FS-1: every bit must be 1; integrator wrap-around would emit a 0.
  task automatic test_fullscale(input logic order);
    int cyc;
    int ones;
    reg_moddiv = 4'd0; reg_modosr = 8'd255; reg_modorder = order;
    @(negedge SYSCLK);
    reg_moden = 1'b1;
    @(negedge SYSCLK);
    send_sample(16'h7FFF);
    ones = 0;
    for (int k = 0; k < 1024; k++) begin
      wait_strobe(cyc);
      if (DSDOUT === 1'b1) ones++;
    end
    n_cmp++; if (ones !== 1024) begin n_err++; $display("FAIL fs_ones_order%0d: got %0d exp 1024", order, ones); end
  endtask

  // Asynchronous reset while running with a full holding register.
  task automatic test_reset_midrun();
    int n;
    send_sample(16'h1111);
    n_cmp++; if (sample_ready !== 1'b0) begin n_err++; $display("FAIL mr_pre_ready: got %b exp 0", sample_ready); end
    n = 0;
    while (SDCLKOUT !== 1'b1 && n < 8) begin
      @(negedge SYSCLK);
      n++;
    end
    n_cmp++; if (SDCLKOUT !== 1'b1) begin n_err++; $display("FAIL mr_pre_sdclk: got %b exp 1", SDCLKOUT); end
    n_cmp++; if (DSDOUT !== 1'b1)   begin n_err++; $display("FAIL mr_pre_dsd: got %b exp 1", DSDOUT); end
    #2 SYSRST = 1'b1;
    #1;
    n_cmp++; if (DSDOUT !== 1'b0)        begin n_err++; $display("FAIL mr_dsd: got %b exp 0", DSDOUT); end
    n_cmp++; if (SDCLKOUT !== 1'b0)      begin n_err++; $display("FAIL mr_sdclk: got %b exp 0", SDCLKOUT); end
    n_cmp++; if (sample_ready !== 1'b1)  begin n_err++; $display("FAIL mr_ready: got %b exp 1", sample_ready); end
    n_cmp++; if (bit_strobe !== 1'b0)    begin n_err++; $display("FAIL mr_strobe: got %b exp 0", bit_strobe); end
    n_cmp++; if (mod_underflow !== 1'b0) begin n_err++; $display("FAIL mr_uflow: got %b exp 0", mod_underflow); end
    @(negedge SYSCLK);
    reg_moden = 1'b0;
    SYSRST = 1'b0;
    @(negedge SYSCLK);
  endtask

  // osr=7 with one sample: underflow on every 8th bit, sample reused; then
  // two more samples fill two boundaries before the next underflow.
  task automatic test_underflow();
    int cyc;
    logic exp_b;
    reg_moddiv = 4'd0; reg_modosr = 8'd7; reg_modorder = 1'b0;
    reg_moden = 1'b1;
    @(negedge SYSCLK);
    send_sample(16'h0000);
    for (int k = 1; k <= 24; k++) begin
      wait_strobe(cyc);
      exp_b = (k <= 2) ? 1'b1 : ((k % 2) == 0);
      n_cmp++; if (cyc !== 2) begin n_err++; $display("FAIL uf_period[%0d]: got %0d exp 2", k, cyc); end
      n_cmp++; if (mod_underflow !== ((k % 8) == 0)) begin n_err++; $display("FAIL uf_pulse[%0d]: got %b exp %b", k, mod_underflow, ((k % 8) == 0)); end
      n_cmp++; if (DSDOUT !== exp_b) begin n_err++; $display("FAIL uf_bit[%0d]: got %b exp %b", k, DSDOUT, exp_b); end
    end
    send_sample(16'h1234);
    n_cmp++; if (sample_ready !== 1'b0) begin n_err++; $display("FAIL uf_ready_full: got %b exp 0", sample_ready); end
    send_sample(16'h5678);
    for (int k = 1; k <= 16; k++) begin
      wait_strobe(cyc);
      n_cmp++; if (mod_underflow !== (k == 16)) begin n_err++; $display("FAIL uf_resume[%0d]: got %b exp %b", k, mod_underflow, (k == 16)); end
    end
    reg_moden = 1'b0;
    @(negedge SYSCLK);
  endtask

  initial begin
    test_reset();
    test_alternating();
    test_disable();
    test_order2_half();
    test_fullscale(1'b0);
    reg_moden = 1'b0;
    @(negedge SYSCLK);
    test_fullscale(1'b1);
    test_reset_midrun();
    test_underflow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
